// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch-stage program-counter generator (optional macro: PC_ALIGN_CHECK_EN)
module pc_gen_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0100),
  parameter int unsigned      INC_BYTES    = 4,
  parameter int unsigned      HOLD_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc_seq,
  output logic             pend_valid,
  output logic             misalign,
  output logic [WIDTH-1:0] misalign_addr
);

  localparam logic [WIDTH-1:0] INC       = WIDTH'(INC_BYTES);
  localparam logic [3:0]       HOLD_INIT = 4'(HOLD_CYCLES);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [3:0]       hold_cnt_q;
  logic [WIDTH-1:0] pc_q;
  logic             pend_valid_q;
  logic [WIDTH-1:0] pend_target_q;

  logic             take_redirect_d;
  logic [WIDTH-1:0] redirect_pc_d;
  logic [WIDTH-1:0] pc_seq_d;

`ifdef PC_ALIGN_CHECK_EN
  // Low bits that must be zero for a target to be a legal fetch address.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC_BYTES - 1);

  logic             misalign_q;
  logic [WIDTH-1:0] misalign_addr_q;
  logic             target_misaligned_d;
`endif

  // Pick the redirect to apply: a live redirect always beats the buffered one.
  always_comb begin
    take_redirect_d = redirect_valid | pend_valid_q;
    redirect_pc_d   = redirect_valid ? redirect_target : pend_target_q;
    pc_seq_d        = pc_q + INC;
`ifdef PC_ALIGN_CHECK_EN
    target_misaligned_d = |(redirect_pc_d & ALIGN_MASK);
`endif
  end

  // Boot/run sequencing and every PC-related register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      hold_cnt_q    <= HOLD_INIT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
`endif
    end else begin
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        ST_BOOT: begin
          // Fetch inputs are ignored until the hold count runs out.
          if (hold_cnt_q == 4'd0) begin
            state_q <= ST_RUN;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
        ST_RUN: begin
          if (exc_req) begin
            pc_q         <= EXC_VECTOR;
            pend_valid_q <= 1'b0;
          end else if (stall) begin
            // Park the newest redirect; it is validated only when applied.
            if (redirect_valid) begin
              pend_valid_q  <= 1'b1;
              pend_target_q <= redirect_target;
            end
          end else if (take_redirect_d) begin
            pend_valid_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (target_misaligned_d) begin
              pc_q            <= EXC_VECTOR;
              misalign_q      <= 1'b1;
              misalign_addr_q <= redirect_pc_d;
            end else begin
              pc_q <= redirect_pc_d;
            end
`else
            pc_q <= redirect_pc_d;
`endif
          end else begin
            pc_q <= pc_seq_d;
          end
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign pc_valid   = (state_q == ST_RUN);
  assign pc_seq     = pc_seq_d;
  assign pend_valid = pend_valid_q;

`ifdef PC_ALIGN_CHECK_EN
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;
`else
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised program-counter generator for the CPU fetch stage; successor to the single-cycle PC register.
- Adds configurable width, reset vector, increment and boot-hold length.
- Adds stall hold, branch/jump redirect, a one-entry pending-redirect buffer for redirects that arrive during a stall, and an exception vector override.
- Drives the instruction-memory address and a valid flag to fetch.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VECTOR, 0, PC value loaded at reset.
- EXC_VECTOR, 32'h0000_0100, PC loaded on exception request.
- INC_BYTES, 4, sequential increment; must be a power of two (ALIGN = log2(INC_BYTES)).
- HOLD_CYCLES, 1, extra BOOT cycles before fetch starts (range 0..15).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- stall, input, 1: hold the current PC.
- redirect_valid, input, 1: branch or jump taken this cycle.
- redirect_target, input, WIDTH: redirect destination.
- exc_req, input, 1: exception or interrupt request.
- pc, output, WIDTH: current fetch address.
- pc_valid, output, 1: pc is a live fetch address.
- pc_seq, output, WIDTH: pc + INC_BYTES, combinational, wraps modulo 2^WIDTH.
- pend_valid, output, 1: a buffered redirect is waiting.
- misalign, output, 1: misaligned-target pulse (optional feature).
- misalign_addr, output, WIDTH: offending target (optional feature).

Behaviour:
- Reset: on a clock edge with rst=1:
  - pc = RESET_VECTOR, state = BOOT, hold_cnt = HOLD_CYCLES.
  - pc_valid = 0, pend_valid = 0, pend_target = 0, misalign = 0, misalign_addr = 0.
  - rst overrides every other input. Reset mid-run discards any pending redirect.
- State BOOT:
  - pc is held at RESET_VECTOR and pc_valid = 0.
  - Each edge: if hold_cnt == 0, go to RUN; otherwise hold_cnt decrements.
  - Result: pc_valid rises HOLD_CYCLES+1 edges after rst falls. The default of 1 gives 2 edges, which reproduces the legacy one-cycle skip.
  - stall, redirect_valid and exc_req are ignored in BOOT.
- State RUN: pc_valid = 1. On each edge, the first matching rule applies:
  1. exc_req=1: pc <= EXC_VECTOR; pend_valid <= 0. Exception beats stall and redirect.
  2. stall=1: pc holds.
     - If redirect_valid=1: pend_target <= redirect_target and pend_valid <= 1.
     - A newer redirect during the same stall overwrites the older one (last wins).
  3. redirect_valid=1: pc <= redirect_target; pend_valid <= 0. A live redirect beats a buffered one.
  4. pend_valid=1: pc <= pend_target; pend_valid <= 0. This takes effect on the first unstalled edge.
  5. Otherwise: pc <= pc + INC_BYTES, truncated to WIDTH bits, so all-ones wraps to 0 with no flag.
- pc_seq is combinational from pc and has no latency.
- pc changes exactly one edge after the qualifying input is sampled.
- No state exists besides: state, hold_cnt, pc, pend_valid, pend_target and the misalign registers.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - In RUN without exc_req, a redirect (live, or buffered when applied) whose low ALIGN bits are non-zero is treated as an exception.
  - The redirect is not taken: pc <= EXC_VECTOR and pend_valid <= 0.
  - misalign pulses 1 for one cycle and misalign_addr <= the offending target.
  - A redirect buffered during stall is checked only when applied, not when buffered.
- Undefined:
  - Targets are used verbatim.
  - misalign and misalign_addr are tied to 0.

Test Plan:
- Boot: rst high for 3 cycles, then low; HOLD_CYCLES=1, RESET_VECTOR=0x1000 -> pc=0x1000 with pc_valid=0 for 2 edges; pc_valid=1 on the 3rd; then 0x1004, 0x1008.
- Wrap: WIDTH=8, INC_BYTES=4, RESET_VECTOR=8'hF8, HOLD_CYCLES=0 -> pc sequence F8, FC, 00, 04; pc_seq=00 while pc=FC.
- Stall plus pending: pc=0x20; stall=1 for 3 cycles with redirect 0x80 in cycle 1 and 0x90 in cycle 2 -> pc stays 0x20 and pend_valid=1; after stall drops, pc=0x90, then 0x94.
- Priority: exc_req=1, redirect_valid=1 (0x40) and stall=1 in the same cycle -> pc=0x100, pend_valid=0. Next, redirect 0x40 with no stall -> pc=0x40.
- Reset mid-operation: pend_valid=1 with pending target 0x80, rst pulsed for one cycle -> pc=RESET_VECTOR, pend_valid=0, pc_valid=0, and 0x80 is never fetched.
- PC_ALIGN_CHECK_EN defined: redirect to 0x42 -> pc=0x100, misalign=1 for exactly one cycle, misalign_addr=0x42. Without the macro: pc=0x42, misalign=0.
